// File: rtl/pipeline_sink_pkg.sv
// Shared payload type for the pipeline sink: one buffered {address, id} transaction.
// The width defines normally come from defines.vh; fallbacks keep this slice self-contained.
`ifndef ADDRESS_WIDTH
`define ADDRESS_WIDTH 16
`endif
`ifndef ID_WIDTH
`define ID_WIDTH 4
`endif

package pipeline_sink_pkg;

    typedef struct packed {
        logic [`ADDRESS_WIDTH-1:0] address;
        logic [`ID_WIDTH-1:0]      id;
    } sink_entry_t;

    localparam int SINK_ENTRY_W = $bits(sink_entry_t);

endpackage

// File: rtl/sink_fifo.sv
// First-word-fall-through FIFO: rd_data always shows the head entry; level tracks occupancy.
module sink_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int LVL_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_data,
    output logic [LVL_W-1:0] level,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic             push_ok, pop_ok;

    assign full    = (level_q == LVL_W'(DEPTH));
    assign empty   = (level_q == '0);
    assign level   = level_q;
    assign rd_data = mem_q[rd_ptr_q];

    // No bypass when full: a pop in the same cycle does not make room for a push.
    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (push_ok) begin
            mem_d[wr_ptr_q] = wr_data;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push_ok, pop_ok})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

endmodule

// File: rtl/pipeline_sink.sv
// Terminal consumer of the address/ID pipeline: buffers transfers for a host reader,
// checks ID ordering and keeps saturating transfer/backpressure statistics.
module pipeline_sink #(
    parameter int DEPTH     = 4,
    parameter int CNT_WIDTH = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [`ADDRESS_WIDTH-1:0] in_address,
    input  logic [`ID_WIDTH-1:0]      in_id,
    input  logic                      in_valid,
    output logic                      out_stall,
    input  logic                      force_stall,
    input  logic                      rd_en,
    output logic                      rd_valid,
    output logic [`ADDRESS_WIDTH-1:0] rd_address,
    output logic [`ID_WIDTH-1:0]      rd_id,
    output logic [$clog2(DEPTH):0]    level,
    output logic [CNT_WIDTH-1:0]      accepted_count,
    output logic [CNT_WIDTH-1:0]      stall_cycles,
    output logic                      order_error,
    output logic [`ID_WIDTH-1:0]      err_expected_id,
    output logic [`ID_WIDTH-1:0]      err_got_id
);

    import pipeline_sink_pkg::*;

    localparam int SINK_PTR_W = $clog2(DEPTH);
    localparam int IDW        = `ID_WIDTH;

    logic        fifo_full, fifo_empty;
    logic        transfer, pop;
    sink_entry_t wr_entry, rd_entry;

    logic [IDW-1:0]       expected_id_q, expected_id_d;
    logic                 order_error_q, order_error_d;
    logic [IDW-1:0]       err_exp_q, err_exp_d;
    logic [IDW-1:0]       err_got_q, err_got_d;
    logic [CNT_WIDTH-1:0] accepted_q, accepted_d;
    logic [CNT_WIDTH-1:0] stall_cnt_q, stall_cnt_d;

    // Valid/ready contract: a transfer happens on any edge where in_valid is high and
    // out_stall is low; upstream holds its data stable while out_stall is high.
    assign out_stall = force_stall | fifo_full;
    assign transfer  = in_valid & ~out_stall;
    assign pop       = rd_en & ~fifo_empty;
    assign rd_valid  = ~fifo_empty;

    assign wr_entry.address = in_address;
    assign wr_entry.id      = in_id;

    sink_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (SINK_ENTRY_W)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push    (transfer),
        .wr_data (wr_entry),
        .pop     (pop),
        .rd_data (rd_entry),
        .level   (level),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign rd_address = rd_entry.address;
    assign rd_id      = rd_entry.id;

    always_comb begin
        expected_id_d = expected_id_q;
        order_error_d = order_error_q;
        err_exp_d     = err_exp_q;
        err_got_d     = err_got_q;
        accepted_d    = accepted_q;
        stall_cnt_d   = stall_cnt_q;
        if (transfer) begin
            // Resynchronise on every transfer so one skip reports once, not forever.
            expected_id_d = in_id + IDW'(1);
            if ((in_id != expected_id_q) && !order_error_q) begin
                order_error_d = 1'b1;
                err_exp_d     = expected_id_q;
                err_got_d     = in_id;
            end
            if (accepted_q != '1) begin
                accepted_d = accepted_q + CNT_WIDTH'(1);
            end
        end
        if (in_valid && out_stall && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            expected_id_q <= '0;
            order_error_q <= 1'b0;
            err_exp_q     <= '0;
            err_got_q     <= '0;
            accepted_q    <= '0;
            stall_cnt_q   <= '0;
        end else begin
            expected_id_q <= expected_id_d;
            order_error_q <= order_error_d;
            err_exp_q     <= err_exp_d;
            err_got_q     <= err_got_d;
            accepted_q    <= accepted_d;
            stall_cnt_q   <= stall_cnt_d;
        end
    end

    assign accepted_count  = accepted_q;
    assign stall_cycles    = stall_cnt_q;
    assign order_error     = order_error_q;
    assign err_expected_id = err_exp_q;
    assign err_got_id      = err_got_q;

endmodule

// File: tb/tb_pipeline_sink.sv
// Directed bench for pipeline_sink: a vector table for the steady-state flow plus
// hand-written sequences for reset, push/pop overlap, ordering errors, wrap and saturation.
`ifndef ADDRESS_WIDTH
`define ADDRESS_WIDTH 16
`endif
`ifndef ID_WIDTH
`define ID_WIDTH 4
`endif

module tb_pipeline_sink;

    localparam int AW  = `ADDRESS_WIDTH;
    localparam int IDW = `ID_WIDTH;
    localparam int CW  = 4;

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic [AW-1:0]  in_address = '0;
    logic [IDW-1:0] in_id = '0;
    logic           in_valid = 1'b0;
    logic           out_stall;
    logic           force_stall = 1'b0;
    logic           rd_en = 1'b0;
    logic           rd_valid;
    logic [AW-1:0]  rd_address;
    logic [IDW-1:0] rd_id;
    logic [2:0]     level;
    logic [CW-1:0]  accepted_count;
    logic [CW-1:0]  stall_cycles;
    logic           order_error;
    logic [IDW-1:0] err_expected_id;
    logic [IDW-1:0] err_got_id;

    int checks = 0;
    int errors = 0;

    pipeline_sink #(.DEPTH(4), .CNT_WIDTH(CW)) dut (
        .clk             (clk),
        .reset           (reset),
        .in_address      (in_address),
        .in_id           (in_id),
        .in_valid        (in_valid),
        .out_stall       (out_stall),
        .force_stall     (force_stall),
        .rd_en           (rd_en),
        .rd_valid        (rd_valid),
        .rd_address      (rd_address),
        .rd_id           (rd_id),
        .level           (level),
        .accepted_count  (accepted_count),
        .stall_cycles    (stall_cycles),
        .order_error     (order_error),
        .err_expected_id (err_expected_id),
        .err_got_id      (err_got_id)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic           valid;
        logic [IDW-1:0] id;
        logic [AW-1:0]  addr;
        logic           fs;
        logic           re;
        logic [2:0]     e_level;
        logic           e_stall;
        logic           e_rdv;
        logic [IDW-1:0] e_rd_id;
        logic [AW-1:0]  e_rd_addr;
        logic [CW-1:0]  e_acc;
        logic [CW-1:0]  e_sc;
        logic           e_oe;
        logic [IDW-1:0] e_ee;
        logic [IDW-1:0] e_eg;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic add(input logic v, input int id, input int addr, input logic fs, input logic re,
                       input int lvl, input logic st, input logic rdv, input int rid, input int raddr,
                       input int acc, input int sc, input logic oe, input int ee, input int eg);
        vec_t t;
        t.valid = v;  t.id = IDW'(id);  t.addr = AW'(addr);  t.fs = fs;  t.re = re;
        t.e_level = 3'(lvl);  t.e_stall = st;  t.e_rdv = rdv;
        t.e_rd_id = IDW'(rid);  t.e_rd_addr = AW'(raddr);
        t.e_acc = CW'(acc);  t.e_sc = CW'(sc);  t.e_oe = oe;
        t.e_ee = IDW'(ee);  t.e_eg = IDW'(eg);
        vecs.push_back(t);
    endtask

    task automatic drive(input logic v, input int id, input int addr, input logic fs, input logic re);
        @(negedge clk);
        in_valid    = v;
        in_id       = IDW'(id);
        in_address  = AW'(addr);
        force_stall = fs;
        rd_en       = re;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        in_valid = 1'b0;  force_stall = 1'b0;  rd_en = 1'b0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        // Main flow: fill to full, stall, pop, overlap, forced stall, ordering error.
        //   valid id addr fs re | level stall rdv rd_id rd_addr acc sc oe ee eg
        add(1, 0, 'h10, 0, 0,   1, 0, 1, 0, 'h10, 1, 0, 0, 0, 0);
        add(1, 1, 'h20, 0, 0,   2, 0, 1, 0, 'h10, 2, 0, 0, 0, 0);
        add(1, 2, 'h30, 0, 0,   3, 0, 1, 0, 'h10, 3, 0, 0, 0, 0);
        add(1, 3, 'h40, 0, 0,   4, 1, 1, 0, 'h10, 4, 0, 0, 0, 0);
        add(1, 4, 'h50, 0, 0,   4, 1, 1, 0, 'h10, 4, 1, 0, 0, 0);
        add(1, 4, 'h50, 0, 0,   4, 1, 1, 0, 'h10, 4, 2, 0, 0, 0);
        add(1, 4, 'h50, 0, 1,   3, 0, 1, 1, 'h20, 4, 3, 0, 0, 0);
        add(1, 4, 'h50, 0, 0,   4, 1, 1, 1, 'h20, 5, 3, 0, 0, 0);
        add(0, 0, 'h00, 0, 1,   3, 0, 1, 2, 'h30, 5, 3, 0, 0, 0);
        add(0, 0, 'h00, 0, 1,   2, 0, 1, 3, 'h40, 5, 3, 0, 0, 0);
        add(1, 5, 'h60, 0, 1,   2, 0, 1, 4, 'h50, 6, 3, 0, 0, 0);
        add(1, 6, 'h70, 1, 0,   2, 1, 1, 4, 'h50, 6, 4, 0, 0, 0);
        add(1, 6, 'h70, 0, 0,   3, 0, 1, 4, 'h50, 7, 4, 0, 0, 0);
        add(1, 8, 'h80, 0, 0,   4, 1, 1, 4, 'h50, 8, 4, 1, 7, 8);
        add(1, 10, 'h90, 0, 1,  3, 0, 1, 5, 'h60, 8, 5, 1, 7, 8);
        add(1, 10, 'h90, 0, 0,  4, 1, 1, 5, 'h60, 9, 5, 1, 7, 8);

        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
        chk("reset level", 32'(level), 0);
        chk("reset rd_valid", 32'(rd_valid), 0);
        chk("reset out_stall", 32'(out_stall), 0);
        chk("reset accepted", 32'(accepted_count), 0);
        chk("reset order_error", 32'(order_error), 0);

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].valid, int'(vecs[i].id), int'(vecs[i].addr), vecs[i].fs, vecs[i].re);
            step();
            chk($sformatf("v%0d level", i), 32'(level), 32'(vecs[i].e_level));
            chk($sformatf("v%0d out_stall", i), 32'(out_stall), 32'(vecs[i].e_stall));
            chk($sformatf("v%0d rd_valid", i), 32'(rd_valid), 32'(vecs[i].e_rdv));
            chk($sformatf("v%0d rd_id", i), 32'(rd_id), 32'(vecs[i].e_rd_id));
            chk($sformatf("v%0d rd_address", i), 32'(rd_address), 32'(vecs[i].e_rd_addr));
            chk($sformatf("v%0d accepted", i), 32'(accepted_count), 32'(vecs[i].e_acc));
            chk($sformatf("v%0d stall_cycles", i), 32'(stall_cycles), 32'(vecs[i].e_sc));
            chk($sformatf("v%0d order_error", i), 32'(order_error), 32'(vecs[i].e_oe));
            chk($sformatf("v%0d err_expected", i), 32'(err_expected_id), 32'(vecs[i].e_ee));
            chk($sformatf("v%0d err_got", i), 32'(err_got_id), 32'(vecs[i].e_eg));
        end

        // Reset mid-stream at level 3: everything clears without a clock edge.
        drive(0, 0, 0, 0, 1);
        step();
        chk("pre-reset level", 32'(level), 3);
        @(negedge clk);
        rd_en = 1'b0;
        reset = 1'b1;
        #1;
        chk("midreset level", 32'(level), 0);
        chk("midreset rd_valid", 32'(rd_valid), 0);
        chk("midreset rd_id", 32'(rd_id), 0);
        chk("midreset accepted", 32'(accepted_count), 0);
        chk("midreset stall_cycles", 32'(stall_cycles), 0);
        chk("midreset order_error", 32'(order_error), 0);
        chk("midreset err_got", 32'(err_got_id), 0);
        chk("midreset out_stall", 32'(out_stall), 0);
        force_stall = 1'b1;
        #1;
        chk("reset force out_stall", 32'(out_stall), 1);
        @(negedge clk);
        force_stall = 1'b0;
        reset = 1'b0;

        // Simultaneous push and pop at level 2 pops the oldest entry.
        drive(1, 0, 'hA0, 0, 0);  step();
        drive(1, 1, 'hB0, 0, 0);  step();
        drive(1, 2, 'hC0, 0, 1);
        #1;
        chk("overlap head before", 32'(rd_id), 0);
        chk("overlap addr before", 32'(rd_address), 'hA0);
        step();
        chk("overlap level", 32'(level), 2);
        chk("overlap head after", 32'(rd_id), 1);
        chk("overlap addr after", 32'(rd_address), 'hB0);
        drive(0, 0, 0, 0, 1);  step();
        drive(0, 0, 0, 0, 1);  step();
        chk("drain rd_valid", 32'(rd_valid), 0);
        drive(0, 0, 0, 0, 1);  step();
        chk("pop empty level", 32'(level), 0);

        // Ordering error capture: IDs 0,1,3,4,6 while the reader keeps up.
        do_reset();
        drive(1, 0, 1, 0, 1);  step();
        drive(1, 1, 2, 0, 1);  step();
        chk("order pre-error", 32'(order_error), 0);
        drive(1, 3, 3, 0, 1);  step();
        chk("order error set", 32'(order_error), 1);
        chk("order err_expected", 32'(err_expected_id), 2);
        chk("order err_got", 32'(err_got_id), 3);
        drive(1, 4, 4, 0, 1);  step();
        drive(1, 6, 6, 0, 1);  step();
        chk("order sticky", 32'(order_error), 1);
        chk("order keep expected", 32'(err_expected_id), 2);
        chk("order keep got", 32'(err_got_id), 3);
        chk("order accepted", 32'(accepted_count), 5);
        chk("order level", 32'(level), 1);

        // ID wrap 15 -> 0 is legal; 17 transfers also saturate the 4-bit counter.
        do_reset();
        for (int i = 0; i < 17; i++) begin
            drive(1, i % 16, i, 0, 1);
            step();
        end
        chk("wrap order_error", 32'(order_error), 0);
        chk("wrap accepted sat", 32'(accepted_count), 15);
        chk("wrap level", 32'(level), 1);
        chk("wrap head id", 32'(rd_id), 0);
        chk("wrap head addr", 32'(rd_address), 16);

        // Forced stall with valid held: stall counter saturates, nothing accepted.
        for (int i = 0; i < 20; i++) begin
            drive(1, 1, 'h77, 1, 0);
            step();
        end
        chk("sat stall_cycles", 32'(stall_cycles), 15);
        chk("sat accepted", 32'(accepted_count), 15);
        chk("sat level", 32'(level), 1);
        chk("sat out_stall", 32'(out_stall), 1);

        drive(0, 0, 0, 0, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
